// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//   Loads two operands and an operation selector from switches. One field is
//   captured per qualified press of a bouncing push button. The raw button is
//   synchronised, optionally debounced, and edge-detected into a single-cycle
//   press that steps the capture FSM S_A -> S_B -> S_OP -> S_DONE -> S_A.
//
//   Build option: define OPERAND_LOADER_DEBOUNCE_EN to include the debounce
//   counter. Without it the synchronised level is used directly and
//   DEBOUNCE_CYCLES has no effect.
//
// Parameters
//   N               operand width
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a new
//                   button level (1..65535)
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   data_sw    operand switches (sampled only on a capture edge)
//   sel_sw     selector switches (sampled only on a capture edge)
//   btn_load   raw load button, active-high
//   operand1   captured first operand
//   operand2   captured second operand
//   selector   captured operation selector
//   valid      one-cycle pulse on the cycle after the selector is captured
//   ready      high while all three fields hold a complete set (S_DONE)
//   state      current FSM encoding, for LED display
// -----------------------------------------------------------------------------
module operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_sw,
  input  logic [3:0]   sel_sw,
  input  logic         btn_load,
  output logic [N-1:0] operand1,
  output logic [N-1:0] operand2,
  output logic [3:0]   selector,
  output logic         valid,
  output logic         ready,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // two-flop synchroniser; nothing else looks at btn_load
  logic [1:0] sync_q;
  logic       btn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_load};
  end

  assign btn_s = sync_q[1];

  logic btn_stable;

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  // The counter tracks how many consecutive edges btn_s has disagreed with the
  // accepted level. Any agreeing sample restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] diff_cnt_q;
  logic        stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diff_cnt_q <= '0;
      stable_q   <= 1'b0;
    end else if (btn_s == stable_q) begin
      diff_cnt_q <= '0;
    end else if (diff_cnt_q == DB_LAST) begin
      stable_q   <= btn_s;
      diff_cnt_q <= '0;
    end else begin
      diff_cnt_q <= diff_cnt_q + 16'd1;
    end
  end

  assign btn_stable = stable_q;
`else
  assign btn_stable = btn_s;

  // parameter kept for a uniform interface; it has no function in this build
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 0);
`endif

  // rising-edge detect on the accepted level, registered so the press pulse
  // lands the cycle after btn_stable rises
  logic stable_prev_q;
  logic press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      stable_prev_q <= btn_stable;
      press_q       <= btn_stable & ~stable_prev_q;
    end
  end

  // capture FSM; every output is a register written only here
  state_t         state_q;
  logic [N-1:0]   op1_q;
  logic [N-1:0]   op2_q;
  logic [3:0]     sel_q;
  logic           valid_q;
  logic           ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (press_q) begin
        case (state_q)
          S_A: begin
            op1_q   <= data_sw;
            state_q <= S_B;
          end
          S_B: begin
            op2_q   <= data_sw;
            state_q <= S_OP;
          end
          S_OP: begin
            sel_q   <= sel_sw;
            state_q <= S_DONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
          S_DONE: begin
            // leaving S_DONE keeps the last set visible on the outputs
            state_q <= S_A;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign operand1 = op1_q;
  assign operand2 = op2_q;
  assign selector = sel_q;
  assign valid    = valid_q;
  assign ready    = ready_q;
  assign state    = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_loader
//   Directed sequences followed by random button/switch activity for
//   operand_loader (N=4, DEBOUNCE_CYCLES=4). A reference model derives the
//   accepted button level from the history of sampled button values, then
//   applies the capture rules to the switch values present at capture edges.
// -----------------------------------------------------------------------------
module tb_operand_loader;

  localparam int D = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_sw = '0;
  logic [3:0] sel_sw = '0;
  logic       btn_load = 1'b0;
  logic [3:0] operand1, operand2, selector;
  logic       valid, ready;
  logic [1:0] state;

  operand_loader #(.N(4), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_sw  (data_sw),
    .sel_sw   (sel_sw),
    .btn_load (btn_load),
    .operand1 (operand1),
    .operand2 (operand2),
    .selector (selector),
    .valid    (valid),
    .ready    (ready),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0, vcount = 0;

  // ---------------- reference model ----------------
  bit       m_bq[$];          // m_bq[0] = button sampled at the latest edge
  bit       m_stab, m_stab_prev, m_press, m_valid;
  bit [1:0] m_st;
  bit [3:0] m_op1, m_op2, m_sel;

  task automatic model_reset();
    m_bq.delete();
    for (int j = 0; j < D + 2; j++) m_bq.push_back(1'b0);
    m_stab = 0; m_stab_prev = 0; m_press = 0; m_valid = 0;
    m_st = 0; m_op1 = 0; m_op2 = 0; m_sel = 0;
  endtask

  task automatic model_edge(input bit r, input bit b, input bit [3:0] d, input bit [3:0] s);
    bit cap, new_press, new_stab;
    if (r) begin
      model_reset();
      return;
    end
    cap = m_press;
    m_bq.push_front(b);
    void'(m_bq.pop_back());
    new_press = m_stab & ~m_stab_prev;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    // the synchronised value seen at this edge is m_bq[2]; the level flips when
    // the last D such values all disagree with the accepted level
    new_stab = ~m_stab;
    for (int j = 2; j <= D + 1; j++) if (m_bq[j] == m_stab) new_stab = m_stab;
`else
    new_stab = m_bq[1];
`endif
    m_stab_prev = m_stab;
    m_stab = new_stab;
    m_press = new_press;
    m_valid = 0;
    if (cap) begin
      case (m_st)
        2'd0: begin m_op1 = d; m_st = 2'd1; end
        2'd1: begin m_op2 = d; m_st = 2'd2; end
        2'd2: begin m_sel = s; m_st = 2'd3; m_valid = 1; end
        default: m_st = 2'd0;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("state",    {6'b0, state},    {6'b0, m_st});
    chk("operand1", {4'b0, operand1}, {4'b0, m_op1});
    chk("operand2", {4'b0, operand2}, {4'b0, m_op2});
    chk("selector", {4'b0, selector}, {4'b0, m_sel});
    chk("valid",    {7'b0, valid},    {7'b0, m_valid});
    chk("ready",    {7'b0, ready},    {7'b0, (m_st == 2'd3)});
  endtask

  // one clock: check outputs, drive inputs at the falling edge, advance model
  task automatic cyc(input bit b, input bit [3:0] d, input bit [3:0] s, input bit r = 1'b0);
    @(negedge clk);
    check_model();
    if (valid === 1'b1) vcount++;
    btn_load = b; data_sw = d; sel_sw = s; reset = r;
    if (r) begin
      #1;
      chk("async_rst_state", {6'b0, state}, 8'h00);
      chk("async_rst_op1",   {4'b0, operand1}, 8'h00);
    end
    @(posedge clk);
    model_edge(r, b, d, s);
  endtask

  task automatic do_reset();
    cyc(1'b0, 4'h0, 4'h0, 1'b1);
    repeat (2) cyc(1'b0, 4'h0, 4'h0);
  endtask

  task automatic press(input bit [3:0] d, input bit [3:0] s);
    repeat (LAT + 1) cyc(1'b1, d, s);
    repeat (LAT + 2) cyc(1'b0, 4'($urandom), 4'($urandom));
  endtask

  int v0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {6'b0, state},    8'h00);
    chk("rst_op1",   {4'b0, operand1}, 8'h00);
    chk("rst_op2",   {4'b0, operand2}, 8'h00);
    chk("rst_sel",   {4'b0, selector}, 8'h00);
    chk("rst_valid", {7'b0, valid},    8'h00);
    chk("rst_ready", {7'b0, ready},    8'h00);
    do_reset();

    // full load sequence
    press(4'h3, 4'h0);
    press(4'hA, 4'h0);
    v0 = vcount;
    press(4'h0, 4'h5);
    #1;
    chk("seq_op1",   {4'b0, operand1}, 8'h03);
    chk("seq_op2",   {4'b0, operand2}, 8'h0A);
    chk("seq_sel",   {4'b0, selector}, 8'h05);
    chk("seq_ready", {7'b0, ready},    8'h01);
    chk("seq_state", {6'b0, state},    8'h03);
    chk("seq_valid_cycles", 8'(vcount - v0), 8'h01);

    // press in S_DONE returns to S_A, fields untouched
    v0 = vcount;
    press(4'hF, 4'hF);
    #1;
    chk("done_state", {6'b0, state},    8'h00);
    chk("done_op1",   {4'b0, operand1}, 8'h03);
    chk("done_op2",   {4'b0, operand2}, 8'h0A);
    chk("done_sel",   {4'b0, selector}, 8'h05);
    chk("done_ready", {7'b0, ready},    8'h00);
    chk("done_valid_cycles", 8'(vcount - v0), 8'h00);

    // capture latency, switches changing up to the capture edge
    do_reset();
    for (int i = 0; i < LAT; i++) cyc(1'b1, 4'(i + 1), 4'h0);
    #1 chk("lat_early_state", {6'b0, state}, 8'h00);
    cyc(1'b1, 4'hC, 4'h0);
    #1;
    chk("lat_state", {6'b0, state},    8'h01);
    chk("lat_op1",   {4'b0, operand1}, 8'h0C);

    // button held long: one capture only
    repeat (50) cyc(1'b1, 4'($urandom), 4'($urandom));
    #1 chk("hold_state", {6'b0, state}, 8'h01);
    repeat (10) cyc(1'b0, 4'($urandom), 4'($urandom));
    #1;
    chk("hold_rel_state", {6'b0, state},    8'h01);
    chk("hold_rel_op1",   {4'b0, operand1}, 8'h0C);
    press(4'hE, 4'h0);
    #1;
    chk("repress_state", {6'b0, state},    8'h02);
    chk("repress_op2",   {4'b0, operand2}, 8'h0E);

    // reset from S_OP discards partial set
    do_reset();
    press(4'h7, 4'h0);
    press(4'h2, 4'h0);
    #1 chk("pre_rst_state", {6'b0, state}, 8'h02);
    cyc(1'b0, 4'h0, 4'h0, 1'b1);
    #1;
    chk("mid_rst_state", {6'b0, state},    8'h00);
    chk("mid_rst_op1",   {4'b0, operand1}, 8'h00);
    chk("mid_rst_op2",   {4'b0, operand2}, 8'h00);
    repeat (2) cyc(1'b0, 4'h0, 4'h0);
    press(4'h6, 4'h0);
    #1;
    chk("post_rst_state", {6'b0, state},    8'h01);
    chk("post_rst_op1",   {4'b0, operand1}, 8'h06);

    do_reset();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    // bouncing button, then steady high
    for (int i = 0; i < 20; i++) cyc(((i / 2) % 2) == 0, 4'h1, 4'h0);
    for (int i = 0; i < LAT; i++) cyc(1'b1, 4'h4, 4'h0);
    #1 chk("bounce_early_state", {6'b0, state}, 8'h00);
    cyc(1'b1, 4'hD, 4'h0);
    #1;
    chk("bounce_state", {6'b0, state},    8'h01);
    chk("bounce_op1",   {4'b0, operand1}, 8'h0D);
    repeat (10) cyc(1'b1, 4'h0, 4'h0);
    repeat (LAT + 2) cyc(1'b0, 4'h0, 4'h0);
    // single-sample glitch is rejected
    cyc(1'b1, 4'h8, 4'h0);
    repeat (LAT + 3) cyc(1'b0, 4'h8, 4'h0);
    #1 chk("glitch_state", {6'b0, state}, 8'h01);
`else
    // single-sample glitch is a press
    cyc(1'b1, 4'h6, 4'h0);
    repeat (2) cyc(1'b0, 4'h6, 4'h0);
    #1 chk("glitch_early_state", {6'b0, state}, 8'h00);
    cyc(1'b0, 4'h6, 4'h0);
    #1;
    chk("glitch_state", {6'b0, state},    8'h01);
    chk("glitch_op1",   {4'b0, operand1}, 8'h06);
`endif

    // random button segments, random switches, occasional reset
    for (int seg = 0; seg < 400; seg++) begin
      bit lvl, rs;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      rs  = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < len; i++)
        cyc(lvl, 4'($urandom), 4'($urandom), rs && (i == 0));
    end
    @(negedge clk);
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
